// File: rtl/decode_stage.sv
// Decode stage: combinational instruction decode into a registered control bundle,
// with a single-entry valid/ready buffer that stalls memory ops for MEM_LAT cycles.
module decode_stage #(
  parameter int OPW     = 9,
  parameter int RAW     = 4,
  parameter int MEM_LAT = 2
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           in_valid,
  input  logic [OPW-1:0] instr,
  output logic           in_ready,
  input  logic           flush,
  input  logic           out_ready,
  output logic           out_valid,
  output logic           Branch,
  output logic           MemtoReg,
  output logic           MemWrite,
  output logic           ALUSrc,
  output logic           RegWrite,
  output logic [RAW-1:0] ReadAddr1,
  output logic [RAW-1:0] ReadAddr2,
  output logic [RAW-1:0] WriteAddr,
  output logic [4:0]     ALUOp,
  output logic [2:0]     Flag,
  output logic           mem_busy
);

  typedef enum logic [1:0] {EMPTY, FULL, MEMWAIT} state_t;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_t     state;
  logic [2:0] count;
  logic [8:0] op;
  logic       accept;

  logic       d_branch, d_memtoreg, d_memwrite, d_alusrc, d_regwrite;
  logic [3:0] d_ra1, d_ra2, d_wa;
  logic [4:0] d_aluop;
  logic       d_mem, d_fload;

  assign op       = instr[8:0];
  assign in_ready = (state == EMPTY) || ((state == FULL) && out_ready);
  assign out_valid = (state == FULL);
  assign mem_busy  = (state == MEMWAIT);
  assign accept    = in_valid && in_ready && !flush;

  // High opcode groups take priority; the mov encoding only applies when bits [8:6] are 0xx.
  always_comb begin
    d_branch   = 1'b0;
    d_memtoreg = 1'b0;
    d_memwrite = 1'b0;
    d_alusrc   = 1'b0;
    d_regwrite = 1'b0;
    d_ra1      = 4'd8;
    d_ra2      = 4'd9;
    d_wa       = 4'd0;
    d_aluop    = 5'b11111;
    d_mem      = 1'b0;
    d_fload    = 1'b0;
    case (op[8:6])
      3'b100: begin
        d_branch = 1'b1;
        d_alusrc = 1'b1;
      end
      3'b101: begin
        d_alusrc   = 1'b1;
        d_regwrite = 1'b1;
        d_memtoreg = 1'b1;
        d_wa       = 4'd15;
      end
      3'b110: begin
        d_wa       = {2'b10, op[4:3]};
        d_alusrc   = |op[2:0];
        d_aluop    = op[5] ? 5'b10001 : 5'b10000;
        d_regwrite = 1'b1;
      end
      3'b111: begin
        if (op[5]) begin
          if (op[4:3] == 2'b00) begin
            d_ra1      = {1'b0, op[2:0]};
            d_ra2      = {1'b0, op[2:0]};
            d_wa       = 4'd15;
            d_regwrite = 1'b1;
            d_memtoreg = 1'b1;
            d_mem      = 1'b1;
          end else if (op[4:3] == 2'b01) begin
            d_ra1      = {1'b0, op[2:0]};
            d_ra2      = {1'b0, op[2:0]};
            d_aluop    = 5'b00000;
            d_memwrite = 1'b1;
            d_mem      = 1'b1;
          end
        end else if (op[4:3] == 2'b11) begin
          d_branch = 1'b1;
          d_fload  = (op[2:0] <= 3'd4);
        end else begin
          d_wa       = {2'b10, op[1:0]};
          d_regwrite = 1'b1;
          case (op[4:2])
            3'b000:  d_aluop = 5'b00100;
            3'b001:  d_aluop = 5'b00101;
            3'b010:  d_aluop = 5'b00000;
            3'b011:  d_aluop = 5'b00001;
            3'b100:  d_aluop = 5'b00010;
            3'b101:  d_aluop = 5'b00011;
            default: begin
              d_aluop    = 5'b11111;
              d_regwrite = 1'b0;
            end
          endcase
        end
      end
      default: begin
        if (!op[0]) begin
          d_ra1      = op[3:0];
          d_ra2      = op[3:0];
          d_wa       = op[7:4];
          d_aluop    = 5'b00000;
          d_regwrite = 1'b1;
        end
      end
    endcase
  end

  // MEMWAIT lasts MEM_LAT-1 cycles so the bundle becomes visible MEM_LAT cycles after acceptance.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= EMPTY;
      count <= 3'd0;
    end else if (flush) begin
      state <= EMPTY;
      count <= 3'd0;
    end else if (accept) begin
      if (d_mem && (MEM_LAT > 1)) begin
        state <= MEMWAIT;
        count <= LAT_M1;
      end else begin
        state <= FULL;
        count <= 3'd0;
      end
    end else begin
      case (state)
        MEMWAIT: begin
          if (count <= 3'd1) begin
            state <= FULL;
            count <= 3'd0;
          end else begin
            count <= count - 3'd1;
          end
        end
        FULL: if (out_ready) state <= EMPTY;
        default: state <= state;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Flag <= 3'd0;
    end else if (accept && d_fload) begin
      Flag <= op[2:0];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Branch    <= 1'b0;
      MemtoReg  <= 1'b0;
      MemWrite  <= 1'b0;
      ALUSrc    <= 1'b0;
      RegWrite  <= 1'b0;
      ReadAddr1 <= RAW'(4'd8);
      ReadAddr2 <= RAW'(4'd9);
      WriteAddr <= RAW'(4'd0);
      ALUOp     <= 5'b11111;
    end else if (accept) begin
      Branch    <= d_branch;
      MemtoReg  <= d_memtoreg;
      MemWrite  <= d_memwrite;
      ALUSrc    <= d_alusrc;
      RegWrite  <= d_regwrite;
      ReadAddr1 <= RAW'(d_ra1);
      ReadAddr2 <= RAW'(d_ra2);
      WriteAddr <= RAW'(d_wa);
      ALUOp     <= d_aluop;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios with literal expectations plus randomized
// traffic checked every cycle against a timestamp-based occupancy model.
module tb_decode_stage;

  localparam int MEM_LAT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [8:0] instr = 9'd0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, mem_busy;
  logic       Branch, MemtoReg, MemWrite, ALUSrc, RegWrite;
  logic [3:0] ReadAddr1, ReadAddr2, WriteAddr;
  logic [4:0] ALUOp;
  logic [2:0] Flag;

  int nVec = 0;
  int nErr = 0;

  decode_stage #(.OPW(9), .RAW(4), .MEM_LAT(MEM_LAT)) dut (
    .Clk(clk), .Reset(rst), .in_valid(in_valid), .instr(instr), .in_ready(in_ready),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .Branch(Branch), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc),
    .RegWrite(RegWrite), .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
    .WriteAddr(WriteAddr), .ALUOp(ALUOp), .Flag(Flag), .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       br, m2r, mw, asrc, rw;
    logic [3:0] ra1, ra2, wa;
    logic [4:0] op;
    logic       mem, fload;
    logic [2:0] fval;
  } ref_t;

  // Occupancy model: the held bundle becomes visible at cycle readyAt.
  logic occ;
  int   readyAt;
  int   cyc;
  ref_t held;
  logic [2:0] flagM;

  function automatic ref_t defaults();
    ref_t r;
    r = '0;
    r.ra1 = 4'd8;
    r.ra2 = 4'd9;
    r.op  = 5'b11111;
    return r;
  endfunction

  function automatic ref_t refDecode(input logic [8:0] i);
    ref_t r;
    logic [4:0] aluTab [8];
    aluTab = '{5'b00100, 5'b00101, 5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b11111, 5'b11111};
    r = defaults();
    if (i[8:6] == 3'b100) begin
      r.br = 1; r.asrc = 1;
    end else if (i[8:6] == 3'b101) begin
      r.asrc = 1; r.rw = 1; r.m2r = 1; r.wa = 15;
    end else if (i[8:6] == 3'b110) begin
      r.wa = 4'd8 + 4'(i[4:3]); r.asrc = (i[2:0] != 0); r.rw = 1;
      r.op = i[5] ? 5'd17 : 5'd16;
    end else if (i[8:5] == 4'b1111 && i[4:3] == 2'b00) begin
      r.ra1 = 4'(i[2:0]); r.ra2 = 4'(i[2:0]); r.wa = 15; r.rw = 1; r.m2r = 1; r.mem = 1;
    end else if (i[8:5] == 4'b1111 && i[4:3] == 2'b01) begin
      r.ra1 = 4'(i[2:0]); r.ra2 = 4'(i[2:0]); r.op = 0; r.mw = 1; r.mem = 1;
    end else if (i[8:5] == 4'b1110 && i[4:3] == 2'b11) begin
      r.br = 1; r.fload = (int'(i[2:0]) <= 4); r.fval = i[2:0];
    end else if (i[8:5] == 4'b1110) begin
      r.wa = 4'd8 + 4'(i[1:0]); r.op = aluTab[int'(i[4:2])]; r.rw = (r.op != 5'b11111);
    end else if (i[8:6] < 3'b100 && i[0] == 1'b0) begin
      r.ra1 = i[3:0]; r.ra2 = i[3:0]; r.wa = i[7:4]; r.op = 0; r.rw = 1;
    end
    return r;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic modelReset();
    occ = 0; readyAt = 0; cyc = 0; held = defaults(); flagM = 3'd0;
  endtask

  // Compares every output against the model, then advances the model across the coming edge.
  task automatic checkOutput();
    logic expValid, expBusy, expInReady, acc;
    ref_t d;
    expValid   = occ && (cyc >= readyAt);
    expBusy    = occ && !expValid;
    expInReady = !occ || (expValid && out_ready);
    cmp("out_valid", 32'(out_valid), 32'(expValid));
    cmp("mem_busy", 32'(mem_busy), 32'(expBusy));
    cmp("in_ready", 32'(in_ready), 32'(expInReady));
    cmp("Flag", 32'(Flag), 32'(flagM));
    if (expValid)
      cmp("bundle", 32'({Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, ReadAddr1, ReadAddr2, WriteAddr, ALUOp}),
          32'({held.br, held.m2r, held.mw, held.asrc, held.rw, held.ra1, held.ra2, held.wa, held.op}));
    acc = in_valid && expInReady && !flush;
    d = refDecode(instr);
    if (flush) begin
      occ = 0;
    end else if (acc) begin
      occ = 1;
      held = d;
      readyAt = cyc + 1 + (d.mem ? MEM_LAT - 1 : 0);
      if (d.fload) flagM = d.fval;
    end else if (expValid && out_ready) begin
      occ = 0;
    end
    cyc++;
  endtask

  task automatic applyStimulus(input logic iv, input logic [8:0] ins, input logic fl, input logic ordy);
    @(negedge clk);
    in_valid = iv; instr = ins; flush = fl; out_ready = ordy;
    #1;
    checkOutput();
    @(posedge clk);
    #2;
  endtask

  task automatic pulseReset();
    in_valid = 0; flush = 0;
    @(negedge clk);
    #2 rst = 1;
    #1;
    cmp("rst out_valid", 32'(out_valid), 0);
    cmp("rst mem_busy", 32'(mem_busy), 0);
    cmp("rst Flag", 32'(Flag), 0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    cmp("post-rst in_ready", 32'(in_ready), 1);
  endtask

  initial begin
    logic [8:0] r;
    modelReset();
    repeat (2) @(posedge clk);
    #2;
    cmp("reset out_valid", 32'(out_valid), 0);
    cmp("reset mem_busy", 32'(mem_busy), 0);
    cmp("reset Flag", 32'(Flag), 0);
    cmp("reset in_ready", 32'(in_ready), 1);
    cmp("reset RA1/RA2/WA", 32'({ReadAddr1, ReadAddr2, WriteAddr}), 32'h890);
    cmp("reset ALUOp", 32'(ALUOp), 32'h1f);
    cmp("reset ctrl", 32'({Branch, MemtoReg, MemWrite, ALUSrc, RegWrite}), 0);
    @(negedge clk);
    rst = 0;

    // mov r3 <- r4
    applyStimulus(1, 9'h034, 0, 1);
    cmp("mov out_valid", 32'(out_valid), 1);
    cmp("mov RA1/RA2/WA", 32'({ReadAddr1, ReadAddr2, WriteAddr}), 32'h443);
    cmp("mov ALUOp", 32'(ALUOp), 0);
    cmp("mov RegWrite", 32'(RegWrite), 1);
    applyStimulus(0, 9'h000, 0, 1);

    // lb r3: one busy cycle, then valid
    applyStimulus(1, 9'h1E3, 0, 0);
    cmp("lb mem_busy", 32'(mem_busy), 1);
    cmp("lb in_ready", 32'(in_ready), 0);
    cmp("lb early valid", 32'(out_valid), 0);
    applyStimulus(0, 9'h000, 0, 0);
    cmp("lb out_valid", 32'(out_valid), 1);
    cmp("lb WA", 32'(WriteAddr), 15);
    cmp("lb MemtoReg", 32'(MemtoReg), 1);
    cmp("lb busy done", 32'(mem_busy), 0);
    applyStimulus(0, 9'h000, 0, 1);

    // add then sub under backpressure
    applyStimulus(1, 9'h1C1, 0, 1);
    cmp("add WA", 32'(WriteAddr), 9);
    cmp("add ALUOp", 32'(ALUOp), 5'b00100);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 9'h1C6, 0, 0);
      cmp("held valid", 32'(out_valid), 1);
      cmp("held WA/ALUOp", 32'({WriteAddr, ALUOp}), 32'({4'd9, 5'b00100}));
    end
    applyStimulus(1, 9'h1C6, 0, 1);
    cmp("sub WA", 32'(WriteAddr), 10);
    cmp("sub ALUOp", 32'(ALUOp), 5'b00101);
    applyStimulus(0, 9'h000, 0, 1);
    cmp("sub no dup", 32'(out_valid), 0);

    // sbf
    applyStimulus(1, 9'h1DA, 0, 1);
    cmp("sbf Flag", 32'(Flag), 2);
    cmp("sbf Branch", 32'(Branch), 1);
    applyStimulus(1, 9'h1DF, 0, 1);
    cmp("sbf7 Flag", 32'(Flag), 2);
    cmp("sbf7 ALUOp", 32'(ALUOp), 5'b11111);
    applyStimulus(0, 9'h000, 0, 1);

    // flush while FULL with a new instruction offered
    applyStimulus(1, 9'h1C1, 0, 0);
    applyStimulus(1, 9'h034, 1, 1);
    cmp("flush out_valid", 32'(out_valid), 0);
    cmp("flush in_ready", 32'(in_ready), 1);
    cmp("flush Flag kept", 32'(Flag), 2);

    // reset during MEMWAIT
    applyStimulus(1, 9'h1E3, 0, 1);
    cmp("memwait busy", 32'(mem_busy), 1);
    pulseReset();
    repeat (3) applyStimulus(0, 9'h000, 0, 1);

    for (int n = 0; n < 3000; n++) begin
      r = 9'($urandom);
      case ($urandom_range(0, 4))
        1: begin r[8:5] = 4'b1111; r[4] = 1'b0; end
        2: r[8:5] = 4'b1110;
        3: r[8:6] = 3'($urandom_range(4, 6));
        4: r[8:6] = 3'($urandom_range(0, 3));
        default: ;
      endcase
      applyStimulus(($urandom_range(0, 9) < 7), r, ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 9) < 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
